lcd_frame_feeder: RTL

- Upstream stage of the LCD `Driver`. It double-buffers the display image written by the game renderer.
- It generates the `start_i` pulse that launches one driver refresh. It then presents frame bytes on `data_i` in the exact order the driver consumes them.
- Byte consumption is tracked by snooping the driver's `en_o`/`dori_o` pins. No address port from the driver is needed.

---
 rtl/lcd_feeder_pkg.sv | 9 +
 rtl/lcd_fb_dpram.sv | 18 +
 rtl/lcd_frame_feeder.sv | 76 +++++++
 3 files changed

// File: rtl/lcd_feeder_pkg.sv
// lcd_feeder_pkg: shared LCD geometry, frame buffer sizing and feeder FSM states
package lcd_feeder_pkg;
  localparam int LCD_W = 128;
  localparam int LCD_H = 64;
  localparam int LCD_PAGE = 8;
  localparam int DEF_DEPTH = LCD_W * LCD_H / LCD_PAGE;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
  typedef enum logic [1:0] {IDLE, START_HI, START_LO, STREAM} state_t;
endpackage

// File: rtl/lcd_fb_dpram.sv
// lcd_fb_dpram: two-bank frame buffer, one write port and one registered read port, bank bit is the address MSB
module lcd_fb_dpram #(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  logic [7:0]      wr_data,
  input  logic [ADDR_W:0] rd_addr,
  output logic [7:0]      rd_data
);
  logic [7:0] mem [2**(ADDR_W+1)];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    rd_data <= !rstn ? 8'd0 : mem[rd_addr];
endmodule

// File: rtl/lcd_frame_feeder.sv
// lcd_frame_feeder: double-buffered LCD frame source that launches driver refreshes and streams bytes; optional LCD_FEEDER_AUTO_REFRESH_EN
module lcd_frame_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int START_HI_CYC = 4,
  parameter int REFRESH_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              frame_done_i,
  input  logic              drv_en_i,
  input  logic              drv_dori_i,
  output logic              start_o,
  output logic [7:0]        data_o,
  output logic              busy_o,
  output logic              front_sel_o
);
  localparam int CW = $clog2(START_HI_CYC);
  state_t state, nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic swap_pend, en_q, tick, consume, take, last;
  assign consume = drv_en_i & ~en_q & drv_dori_i;
  assign take = (state == IDLE) & swap_pend;
  assign last = consume && (rd_ptr == ADDR_W'(DEPTH - 1));
`ifdef LCD_FEEDER_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYC);
  logic [RW-1:0] ref_cnt;
  assign tick = ref_cnt == RW'(REFRESH_CYC - 1);
  always_ff @(posedge clk)
    ref_cnt <= (!rstn || tick) ? '0 : ref_cnt + 1'b1;
`else
  assign tick = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= !rstn ? IDLE : nxt;
  always_comb begin
    nxt = state;
    start_o = state == START_HI;
    busy_o = state != IDLE;
    case (state)
      IDLE:     nxt = (swap_pend || tick) ? START_HI : IDLE;
      START_HI: nxt = (cnt == CW'(START_HI_CYC - 1)) ? START_LO : START_HI;
      START_LO: nxt = STREAM;
      default:  nxt = last ? IDLE : STREAM;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      rd_ptr <= '0;
      swap_pend <= 1'b0;
      cnt <= '0;
      en_q <= 1'b0;
      front_sel_o <= 1'b0;
    end else begin
      en_q <= drv_en_i;
      swap_pend <= frame_done_i | (swap_pend & ~take);
      front_sel_o <= front_sel_o ^ take;
      cnt <= (state == START_HI && nxt == START_HI) ? cnt + 1'b1 : '0;
      rd_ptr <= (state == IDLE) ? '0 : (state == STREAM && consume) ? rd_ptr + 1'b1 : rd_ptr;
    end
  lcd_fb_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en_i),
    .wr_addr ({~front_sel_o, wr_addr_i}),
    .wr_data (wr_data_i),
    .rd_addr ({front_sel_o, rd_ptr}),
    .rd_data (data_o)
  );
endmodule
